// File: rtl/max_pool_stream_pkg.sv
// max_pool_stream_pkg: shared FSM encoding, counter width helper and signed max
package max_pool_stream_pkg;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction
  // Operands arrive sign-extended to 64 bits so any pixel width up to 64 shares one helper
  function automatic logic signed [63:0] smax(input logic signed [63:0] a, input logic signed [63:0] b);
    return (a >= b) ? a : b;
  endfunction
endpackage

// File: rtl/max_pool_stream_if.sv
// max_pool_stream_if: conv pixel in / pooled pixel out stream pair
interface max_pool_stream_if #(
  parameter int DATA_W = 16
);
  logic                     in_valid;
  logic signed [DATA_W-1:0] in_data;
  logic                     out_valid;
  logic signed [DATA_W-1:0] out_data;
  modport master (output in_valid, output in_data, input out_valid, input out_data);
  modport slave (input in_valid, input in_data, output out_valid, output out_data);
endinterface

// File: rtl/max_pool_stream_pool_line_buf.sv
// pool_line_buf: half-row store of horizontal maxima, registered write, async read
module pool_line_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 2,
  parameter int AW     = 1
) (
  input  logic                     clk1,
  input  logic                     we,
  input  logic [AW-1:0]            waddr,
  input  logic signed [DATA_W-1:0] wdata,
  input  logic [AW-1:0]            raddr,
  output logic signed [DATA_W-1:0] rdata
);
  logic signed [DATA_W-1:0] mem_q [DEPTH];
  always_ff @(posedge clk1) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata = mem_q[raddr];
endmodule

// File: rtl/max_pool_stream.sv
// max_pool_stream: 2x2/stride-2 signed max-pool over a raster conv stream, or 1-cycle bypass
module max_pool_stream
  import max_pool_stream_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int OFM_SIZE = 4,
  parameter int CO       = 4
) (
  input  logic             clk1,
  input  logic             rst,
  input  logic             start,
  input  logic             pool_en,
  max_pool_stream_if.slave s,
  output logic             busy,
  output logic             end_pool
);
  localparam int CW   = cnt_w(OFM_SIZE);
  localparam int HW   = cnt_w(CO);
  localparam int LB_D = (OFM_SIZE / 2 > 0) ? OFM_SIZE / 2 : 1;
  localparam int AW   = (LB_D > 1) ? $clog2(LB_D) : 1;
  logic [1:0]               state_q, state_d;
  logic                     mode_q, mode_d;
  logic [CW-1:0]            col_q, col_d, row_q, row_d;
  logic [HW-1:0]            ch_q, ch_d;
  logic signed [DATA_W-1:0] h_q, h_d, out_data_q, out_data_d;
  logic signed [DATA_W-1:0] hmax, lb_rd, pooled;
  logic                     out_valid_q, out_valid_d, end_q, end_d;
  logic                     idle, acc, col_last, row_last, ch_last, last_px, lb_we;
  logic [AW-1:0]            lb_addr;
  always_comb begin
    idle        = state_q == S_IDLE;
    acc         = (state_q == S_RUN) & s.in_valid;
    col_last    = col_q == CW'(OFM_SIZE - 1);
    row_last    = row_q == CW'(OFM_SIZE - 1);
    ch_last     = ch_q == HW'(CO - 1);
    last_px     = acc & col_last & row_last & ch_last;
    lb_addr     = AW'(col_q >> 1);
    hmax        = DATA_W'(smax(64'(h_q), 64'($signed(s.in_data))));
    pooled      = DATA_W'(smax(64'(lb_rd), 64'(hmax)));
    lb_we       = acc & mode_q & col_q[0] & ~row_q[0];
    state_d     = idle ? (start ? S_RUN : S_IDLE) : (state_q == S_RUN) ? (last_px ? S_DONE : S_RUN) : S_IDLE;
    mode_d      = (idle & start) ? pool_en : mode_q;
    col_d       = idle ? '0 : acc ? (col_last ? '0 : col_q + CW'(1)) : col_q;
    row_d       = idle ? '0 : (acc & col_last) ? (row_last ? '0 : row_q + CW'(1)) : row_q;
    ch_d        = idle ? '0 : (acc & col_last & row_last) ? (ch_last ? '0 : ch_q + HW'(1)) : ch_q;
    h_d         = (acc & ~col_q[0]) ? s.in_data : h_q;
    // a window closes on the odd column of an odd row; the odd-size fringe never qualifies
    out_valid_d = acc & (~mode_q | (col_q[0] & row_q[0]));
    out_data_d  = out_valid_d ? (mode_q ? pooled : s.in_data) : out_data_q;
    end_d       = last_px;
  end
  always_ff @(posedge clk1) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mode_q      <= 1'b0;
      col_q       <= '0;
      row_q       <= '0;
      ch_q        <= '0;
      h_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      end_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      col_q       <= col_d;
      row_q       <= row_d;
      ch_q        <= ch_d;
      h_q         <= h_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      end_q       <= end_d;
    end
  end
  pool_line_buf #(.DATA_W(DATA_W), .DEPTH(LB_D), .AW(AW)) u_lb (
    .clk1  (clk1),
    .we    (lb_we),
    .waddr (lb_addr),
    .wdata (hmax),
    .raddr (lb_addr),
    .rdata (lb_rd)
  );
  assign s.out_valid = out_valid_q;
  assign s.out_data  = out_data_q;
  assign busy        = state_q == S_RUN;
  assign end_pool    = end_q;
endmodule

// File: tb/tb_max_pool_stream.sv
// tb_max_pool_stream: randomized streams on a 4x4/CO=2 and a 5x5/CO=1 pool stage vs a window-level model
module tb_max_pool_stream;
  logic clk1 = 1'b0;
  logic rst = 1'b1;
  logic start_a = 1'b0;
  logic start_b = 1'b0;
  logic pool_en = 1'b0;
  logic busy_a, busy_b, end_a, end_b;
  int cyc = 0;
  int n_chk = 0;
  int n_ok = 0;
  logic signed [15:0] px[$], rd[$], ed[$], oa_d[$], ob_d[$];
  int tm[$], rt[$], et[$], re[$], oa_t[$], ob_t[$], ea[$], eb[$];
  int s1[4] = '{6, 8, 14, 16};
  int s4[4] = '{7, 9, 17, 19};

  max_pool_stream_if #(.DATA_W(16)) ia ();
  max_pool_stream_if #(.DATA_W(16)) ib ();

  max_pool_stream #(.DATA_W(16), .OFM_SIZE(4), .CO(2)) ua (
    .clk1(clk1), .rst(rst), .start(start_a), .pool_en(pool_en), .s(ia), .busy(busy_a), .end_pool(end_a));
  max_pool_stream #(.DATA_W(16), .OFM_SIZE(5), .CO(1)) ub (
    .clk1(clk1), .rst(rst), .start(start_b), .pool_en(pool_en), .s(ib), .busy(busy_b), .end_pool(end_b));

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;
  always @(negedge clk1) begin
    if (ia.out_valid) begin oa_d.push_back(ia.out_data); oa_t.push_back(cyc); end
    if (ib.out_valid) begin ob_d.push_back(ib.out_data); ob_t.push_back(cyc); end
    if (end_a) ea.push_back(cyc);
    if (end_b) eb.push_back(cyc);
  end

  task automatic check(input string tag, input int act, input int exp);
    n_chk++;
    if (act == exp) n_ok++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
  endtask

  task automatic drive(input int d, input logic v, input logic signed [15:0] x);
    if (d == 0) begin ia.in_valid = v; ia.in_data = x; end
    else begin ib.in_valid = v; ib.in_data = x; end
  endtask

  task automatic set_start(input int d, input logic v);
    if (d == 0) start_a = v;
    else start_b = v;
  endtask

  function automatic int max4(input int a, input int b, input int c, input int e);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (e > m) m = e;
    return m;
  endfunction

  // Drives one full layer, with junk pixels while idle/done, then scores against the window model
  task automatic run(input int d, input logic pool, input int kind, input logic gaps, input logic poke);
    int ofm, co, n, b;
    logic signed [15:0] v;
    logic signed [15:0] sig [8];
    sig = '{-16'sd5, -16'sd3, -16'sd1, 16'sd0, -16'sd7, -16'sd9, -16'sd2, -16'sd2};
    ofm = (d == 0) ? 4 : 5;
    co = (d == 0) ? 2 : 1;
    n = ofm * ofm * co;
    px.delete(); tm.delete();
    oa_d.delete(); oa_t.delete(); ob_d.delete(); ob_t.delete(); ea.delete(); eb.delete();
    pool_en = pool;
    drive(d, 1'b1, 16'sd999);
    @(negedge clk1);
    set_start(d, 1'b1);
    @(negedge clk1);
    set_start(d, 1'b0);
    pool_en = ~pool;
    for (int k = 0; k < n; k++) begin
      drive(d, 1'b0, '0);
      if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk1);
      v = (kind == 0) ? 16'(k + 1) : (kind == 1) ? 16'($urandom) : 16'($urandom_range(0, 15)) - 16'sd8;
      if (kind == 3 && k < 8) v = sig[k];
      drive(d, 1'b1, v);
      if (poke && k == 5) set_start(d, 1'b1);
      px.push_back(v);
      tm.push_back(cyc + 1);
      @(negedge clk1);
      set_start(d, 1'b0);
    end
    drive(d, 1'b1, 16'sd777);
    repeat (3) @(negedge clk1);
    drive(d, 1'b0, '0);
    repeat (3) @(negedge clk1);
    ed.delete(); et.delete();
    if (!pool) begin
      for (int k = 0; k < n; k++) begin ed.push_back(px[k]); et.push_back(tm[k]); end
    end else begin
      for (int c = 0; c < co; c++)
        for (int r = 0; r < ofm / 2; r++)
          for (int x = 0; x < ofm / 2; x++) begin
            b = c * ofm * ofm + 2 * r * ofm + 2 * x;
            ed.push_back(16'(max4(px[b], px[b + 1], px[b + ofm], px[b + ofm + 1])));
            et.push_back(tm[b + ofm + 1]);
          end
    end
    if (d == 0) begin rd = oa_d; rt = oa_t; re = ea; end
    else begin rd = ob_d; rt = ob_t; re = eb; end
    check("n_out", rd.size(), ed.size());
    for (int i = 0; i < ed.size() && i < rd.size(); i++) begin
      check($sformatf("data[%0d]", i), rd[i], ed[i]);
      check($sformatf("lat[%0d]", i), rt[i], et[i]);
    end
    check("n_end", re.size(), 1);
    if (re.size() > 0) check("end_t", re[0], tm[n - 1]);
    check("busy_after", int'((d == 0) ? busy_a : busy_b), 0);
  endtask

  initial begin
    drive(0, 1'b0, '0);
    drive(1, 1'b0, '0);
    repeat (2) @(negedge clk1);
    check("rst_vld_a", int'(ia.out_valid), 0);
    check("rst_dat_a", ia.out_data, 0);
    check("rst_busy_a", int'(busy_a), 0);
    check("rst_end_a", int'(end_a), 0);
    check("rst_vld_b", int'(ib.out_valid), 0);
    check("rst_dat_b", ib.out_data, 0);
    check("rst_busy_b", int'(busy_b), 0);
    check("rst_end_b", int'(end_b), 0);
    rst = 1'b0;
    @(negedge clk1);
    run(0, 1'b1, 0, 1'b0, 1'b0);
    if (rd.size() >= 4) for (int i = 0; i < 4; i++) check("ramp_win", rd[i], s1[i]);
    run(0, 1'b1, 3, 1'b0, 1'b0);
    if (rd.size() >= 2) begin
      check("signed_w0", rd[0], -3);
      check("signed_w1", rd[1], 0);
    end
    run(0, 1'b0, 1, 1'b1, 1'b0);
    check("bypass_cnt", rd.size(), 32);
    run(1, 1'b1, 0, 1'b0, 1'b0);
    check("odd_cnt", rd.size(), 4);
    if (rd.size() >= 4) for (int i = 0; i < 4; i++) check("odd_win", rd[i], s4[i]);
    pool_en = 1'b1;
    start_a = 1'b1;
    @(negedge clk1);
    start_a = 1'b0;
    for (int k = 0; k < 9; k++) begin drive(0, 1'b1, 16'(k + 1)); @(negedge clk1); end
    drive(0, 1'b0, '0);
    check("busy_run", int'(busy_a), 1);
    rst = 1'b1;
    @(negedge clk1);
    rst = 1'b0;
    oa_d.delete(); oa_t.delete(); ea.delete();
    repeat (4) @(negedge clk1);
    check("rst_mid_out", oa_d.size(), 0);
    check("rst_mid_busy", int'(busy_a), 0);
    run(0, 1'b1, 0, 1'b0, 1'b0);
    if (rd.size() >= 4) for (int i = 0; i < 4; i++) check("post_rst_win", rd[i], s1[i]);
    run(0, 1'b1, 1, 1'b1, 1'b1);
    run(1, 1'b0, 2, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) run($urandom_range(0, 1), 1'($urandom_range(0, 1)), $urandom_range(1, 2), 1'b1, 1'b0);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
